// File: rtl/conv_window_fetch_ctrl_if.sv
// conv_window_fetch_ctrl_if
// Window fetch bus. The sequencer (master) drives the window RAM read strobe,
// address and counters, plus the valid/qualifier side towards the 3x3 conv
// stage. The conv stage (slave) answers with win_ready.
interface conv_window_fetch_ctrl_if #(
  parameter int ADDR_W = 26
);
  logic              need_data;
  logic [ADDR_W-1:0] needed_addr;
  logic [9:0]        counter_row;
  logic [6:0]        counter_col;
  logic              win_ready;
  logic              win_valid;
  logic              win_last_col;
  logic              win_last;
  logic [2:0]        dup_cols;

  modport master (
    output need_data, needed_addr, counter_row, counter_col,
    output win_valid, win_last_col, win_last, dup_cols,
    input  win_ready
  );

  modport slave (
    input  need_data, needed_addr, counter_row, counter_col,
    input  win_valid, win_last_col, win_last, dup_cols,
    output win_ready
  );
endinterface

// File: rtl/conv_window_fetch_ctrl.sv
// conv_window_fetch_ctrl
// Raster-order window sequencer in front of the 3-channel window RAM.
// Each row is swept in strips of STEP columns; when the row width does not
// divide evenly, a final strip is clamped to start at IMG_W-WIN_W, and its
// leading outputs that overlap the previous strip are flagged in dup_cols.
// The RAM registers a window one clock after a need_data cycle, so win_valid
// is raised on the edge after each issue and held until the conv stage
// takes it with win_ready.
// Optional feature macro: FETCH_STALL_CNT_EN (backpressure cycle counter on
// stall_cycles; tied to zero when the macro is not defined).
module conv_window_fetch_ctrl #(
  parameter int IMG_W     = 640,
  parameter int IMG_H     = 640,
  parameter int WIN_W     = 10,
  parameter int STEP      = 8,
  parameter int ADDR_W    = 26,
  parameter int BASE_ADDR = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  conv_window_fetch_ctrl_if.master win,
  output logic        busy,
  output logic        done,
  output logic [31:0] stall_cycles
);

  // Column of the clamped last strip, index of that strip, and how many of
  // its leading outputs were already produced by the strip before it.
  localparam int CLAMP_COL  = IMG_W - WIN_W;
  localparam int LAST_STRIP = (CLAMP_COL + STEP - 1) / STEP;
  localparam int DUP        = LAST_STRIP * STEP - CLAMP_COL;
  localparam int LAST_ROW   = IMG_H - 3;

  localparam logic [ADDR_W-1:0] BASE_A  = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] PITCH_A = ADDR_W'(IMG_W);
  localparam logic [ADDR_W-1:0] STEP_A  = ADDR_W'(STEP);
  localparam logic [ADDR_W-1:0] CLAMP_A = ADDR_W'(CLAMP_COL);
  localparam logic [6:0]        LAST_STRIP_C = 7'(LAST_STRIP);
  localparam logic [6:0]        PRE_LAST_C   = 7'(LAST_STRIP - 1);
  localparam logic [9:0]        LAST_ROW_C   = 10'(LAST_ROW);
  localparam logic [2:0]        DUP_C        = 3'(DUP);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state, state_next;

  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] row_base_q;
  logic [9:0]        row_q;
  logic [6:0]        col_q;
  logic              valid_q;
  logic              last_col_q;
  logic              last_q;
  logic [2:0]        dup_q;

  logic need_c;
  logic issue;
  logic handshake;
  logic start_accept;
  logic kill;
  logic at_last_col;
  logic at_pre_last_col;
  logic final_issue;

  assign handshake       = valid_q && win.win_ready;
  assign start_accept    = (state == IDLE) && start && !abort;
  assign kill            = abort && (state != IDLE);
  assign at_last_col     = (col_q == LAST_STRIP_C);
  assign at_pre_last_col = (col_q == PRE_LAST_C);
  assign final_issue     = at_last_col && (row_q == LAST_ROW_C);
  assign issue           = need_c;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state selection; abort beats every other transition once running.
  always_comb begin
    state_next = state;
    if (kill) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    if (start_accept) state_next = RUN;
        RUN:     if (issue && final_issue) state_next = DRAIN;
        DRAIN:   if (handshake) state_next = DONE;
        DONE:    state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // State-decoded outputs: the RAM read strobe fires whenever the held window
  // slot is free or being consumed this cycle.
  always_comb begin
    need_c = (state == RUN) && (!valid_q || win.win_ready);
    busy   = (state != IDLE);
    done   = (state == DONE);
  end

  // Address and counter walk; row_base tracks the start of the current row so
  // the next row address is one addition away and no multiply is needed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q     <= '0;
      row_base_q <= '0;
      row_q      <= '0;
      col_q      <= '0;
    end else if (kill) begin
      addr_q     <= '0;
      row_base_q <= '0;
      row_q      <= '0;
      col_q      <= '0;
    end else if (start_accept) begin
      addr_q     <= BASE_A;
      row_base_q <= BASE_A;
      row_q      <= '0;
      col_q      <= '0;
    end else if (issue && !final_issue) begin
      if (at_last_col) begin
        addr_q     <= row_base_q + PITCH_A;
        row_base_q <= row_base_q + PITCH_A;
        row_q      <= row_q + 10'd1;
        col_q      <= '0;
      end else if (at_pre_last_col) begin
        addr_q <= row_base_q + CLAMP_A;
        col_q  <= col_q + 7'd1;
      end else begin
        addr_q <= addr_q + STEP_A;
        col_q  <= col_q + 7'd1;
      end
    end
  end

  // Window valid flag and its qualifiers, captured from the issued window so
  // they line up with the data the RAM presents one clock later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= 1'b0;
      last_col_q <= 1'b0;
      last_q     <= 1'b0;
      dup_q      <= '0;
    end else if (kill || start_accept) begin
      valid_q    <= 1'b0;
      last_col_q <= 1'b0;
      last_q     <= 1'b0;
      dup_q      <= '0;
    end else if (issue) begin
      valid_q    <= 1'b1;
      last_col_q <= at_last_col;
      last_q     <= final_issue;
      dup_q      <= at_last_col ? DUP_C : 3'd0;
    end else if (handshake && (state == RUN || state == DRAIN)) begin
      valid_q <= 1'b0;
    end
  end

`ifdef FETCH_STALL_CNT_EN
  logic [31:0] stall_q;

  // Count cycles where a window sits waiting on the conv stage; saturates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else if (start_accept) begin
      stall_q <= '0;
    end else if ((state != IDLE) && valid_q && !win.win_ready && (stall_q != '1)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_cycles = stall_q;
`else
  assign stall_cycles = '0;
`endif

  assign win.need_data    = need_c;
  assign win.needed_addr  = addr_q;
  assign win.counter_row  = row_q;
  assign win.counter_col  = col_q;
  assign win.win_valid    = valid_q;
  assign win.win_last_col = last_col_q;
  assign win.win_last     = last_q;
  assign win.dup_cols     = dup_q;

endmodule
